// File: rtl/fetch_prefetch_queue.sv
// fetch_prefetch_queue: instruction-fetch front end of the RV32 pipeline.
// Owns the fetch PC, issues req/gnt/rvalid requests to instruction memory,
// buffers returned words with their PCs in an in-order prefetch queue and
// presents the head to the fetch/decode register. Redirects come from
// execute and stalls come from decode.
//
// Memory handshake: a request transfers when imem_req_o && imem_gnt_i are both
// high in the same cycle. Each granted request gets exactly one imem_rvalid_i
// pulse, in order, at least one cycle later. While imem_req_o is high and not
// granted, imem_addr_o holds steady.
//
// Optional feature: define FETCH_PERF_CNT_EN to build the fetch-starved cycle
// counter on perf_stall_cnt_o. Otherwise that output is tied to zero.
module fetch_prefetch_queue #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          DEPTH           = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        pc_select_i,
  input  logic [31:0] pc_branch_i,
  input  logic        stall_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] instruction_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_src_o,
  output logic        valid_o,
  output logic [31:0] perf_stall_cnt_o
);

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW:0]   DEPTH_W = (CW + 1)'(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] MAX_C   = CW'(MAX_OUTSTANDING);

  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [31:0]   q_pc    [DEPTH];
  logic [31:0]   q_instr [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard;

  logic        credit;
  logic        grant;
  logic        push;
  logic        pop;
  logic [31:0] target;
  logic        unused_target_bits;

  // Redirect targets are forced word aligned; the low bits are ignored.
  assign target             = {pc_branch_i[31:2], 2'b00};
  assign unused_target_bits = ^pc_branch_i[1:0];

  // Credit reserves a queue slot for every in-flight request, so a response
  // always has room even if decode stalls for a long time.
  assign credit = (({1'b0, count} + {1'b0, outstanding}) < DEPTH_W) &&
                  (outstanding < MAX_C);

  assign imem_req_o  = credit && !pc_select_i && !reset_i;
  assign imem_addr_o = fetch_pc;
  assign grant       = imem_req_o && imem_gnt_i;

  // Responses owed to a pre-redirect request are consumed by the discard count.
  assign push = imem_rvalid_i && (discard == '0) && !pc_select_i;

  // Head presentation is decoded from registered state only.
  assign valid_o       = (count != '0);
  assign instruction_o = valid_o ? q_instr[rd_ptr] : NOP;
  assign pc_o          = valid_o ? q_pc[rd_ptr] : resp_pc;
  assign pc_src_o      = pc_o + 32'd4;

  // A redirect voids the pop of its cycle because the queue is flushed anyway.
  assign pop = valid_o && !stall_i && !pc_select_i;

  // Control state: PCs, queue pointers/occupancy and in-flight bookkeeping.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
    end else if (pc_select_i) begin
      fetch_pc    <= target;
      resp_pc     <= target;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      // Every request still in flight returns a word that must be dropped,
      // except one arriving right now, which is dropped in this cycle.
      outstanding <= outstanding - CW'(imem_rvalid_i);
      discard     <= outstanding - CW'(imem_rvalid_i);
    end else begin
      if (grant) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (push) begin
        resp_pc <= resp_pc + 32'd4;
        wr_ptr  <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count       <= count + CW'(push) - CW'(pop);
      outstanding <= outstanding + CW'(grant) - CW'(imem_rvalid_i);
      if (imem_rvalid_i && (discard != '0)) begin
        discard <= discard - CW'(1);
      end
    end
  end

  // Queue storage: write the returning word and its PC at the tail.
  always_ff @(posedge clk_i) begin
    if (push && !reset_i) begin
      q_pc[wr_ptr]    <= resp_pc;
      q_instr[wr_ptr] <= imem_rdata_i;
    end
    assert (reset_i || !(push && (count == DEPTH_C) && !pop));
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_cnt;

  // Count cycles where decode is ready but fetch has nothing to offer.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      perf_cnt <= '0;
    end else if (!valid_o && !stall_i && (perf_cnt != 32'hFFFF_FFFF)) begin
      perf_cnt <= perf_cnt + 32'd1;
    end
  end

  assign perf_stall_cnt_o = perf_cnt;
`else
  assign perf_stall_cnt_o = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// tb_fetch_prefetch_queue: scoreboard bench for fetch_prefetch_queue.
// The reference is the program-order view: after reset or a redirect, the
// instructions decode consumes must be target, target+4, ... with the memory
// image word for each PC. The bench also plays instruction memory.
module tb_fetch_prefetch_queue;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 4;
  localparam int          MAX_OUT  = 2;
  localparam logic [31:0] NOP      = 32'h0000_0013;
`ifdef FETCH_PERF_CNT_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  logic        clk_i;
  logic        reset_i;
  logic        pc_select_i;
  logic [31:0] pc_branch_i;
  logic        stall_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] instruction_o;
  logic [31:0] pc_o;
  logic [31:0] pc_src_o;
  logic        valid_o;
  logic [31:0] perf_stall_cnt_o;

  fetch_prefetch_queue #(
    .RESET_PC        (RESET_PC),
    .DEPTH           (DEPTH),
    .MAX_OUTSTANDING (MAX_OUT)
  ) dut (
    .clk_i            (clk_i),
    .reset_i          (reset_i),
    .pc_select_i      (pc_select_i),
    .pc_branch_i      (pc_branch_i),
    .stall_i          (stall_i),
    .imem_req_o       (imem_req_o),
    .imem_addr_o      (imem_addr_o),
    .imem_gnt_i       (imem_gnt_i),
    .imem_rvalid_i    (imem_rvalid_i),
    .imem_rdata_i     (imem_rdata_i),
    .instruction_o    (instruction_o),
    .pc_o             (pc_o),
    .pc_src_o         (pc_src_o),
    .valid_o          (valid_o),
    .perf_stall_cnt_o (perf_stall_cnt_o)
  );

  // ---------------- clock ----------------
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // ---------------- bookkeeping ----------------
  int n_cmp = 0;
  int n_err = 0;
  int n_out = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory image: every address holds a distinct, address-derived word.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // ---------------- scoreboard: expected program-order stream ----------------
  logic [63:0] exp_q[$];
  logic [31:0] next_exp_pc;

  function automatic void seed_stream(input logic [31:0] pc);
    exp_q.delete();
    next_exp_pc = pc;
  endfunction

  function automatic void extend_stream();
    while (exp_q.size() < 8) begin
      exp_q.push_back({next_exp_pc, mem_word(next_exp_pc)});
      next_exp_pc = next_exp_pc + 32'd4;
    end
  endfunction

  // ---------------- shared control ----------------
  bit          mon_en        = 1'b0;
  bit          exp_addr_flag = 1'b0;
  logic [31:0] exp_addr      = '0;
  int          gnt_pct       = 100;
  int          lat_min       = 1;
  int          lat_max       = 1;
  int          gnt_off       = 0;

  // ---------------- instruction memory model ----------------
  logic [63:0] pend_q[$];   // {addr, ready_cycle}
  int          mem_cyc = 0;
  bit          hold_flag = 1'b0;
  logic [31:0] hold_addr = '0;

  initial begin
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    forever begin
      @(negedge clk_i);
      mem_cyc++;
      if (gnt_off > 0) begin
        imem_gnt_i = 1'b0;
        gnt_off--;
      end else begin
        imem_gnt_i = ($urandom_range(1, 100) <= gnt_pct);
      end
      if (pend_q.size() > 0 && pend_q[0][31:0] <= 32'(mem_cyc)) begin
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = mem_word(pend_q[0][63:32]);
      end else begin
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = $urandom;
      end
      #4;
      if (mon_en) begin
        if (reset_i || pc_select_i) begin
          check("req_low_in_redirect_or_reset", {31'b0, imem_req_o}, 32'd0);
          hold_flag = 1'b0;
        end else begin
          if (exp_addr_flag && imem_req_o) begin
            check("first_req_after_redirect", imem_addr_o, exp_addr);
            exp_addr_flag = 1'b0;
          end
          if (hold_flag && imem_req_o) check("addr_stable_until_gnt", imem_addr_o, hold_addr);
          if (imem_req_o) check("outstanding_limit", {31'b0, pend_q.size() < MAX_OUT}, 32'd1);
          hold_flag = imem_req_o && !imem_gnt_i;
          hold_addr = imem_addr_o;
        end
      end
      if (reset_i) begin
        pend_q.delete();
      end else begin
        if (imem_rvalid_i) void'(pend_q.pop_front());
        if (imem_req_o && imem_gnt_i)
          pend_q.push_back({imem_addr_o, 32'(mem_cyc + int'($urandom_range(lat_min, lat_max)))});
      end
    end
  end

  // ---------------- output monitor ----------------
  logic [31:0] perf_exp = '0;
  logic        p_valid = 1'b0, p_stall = 1'b0, p_sel = 1'b0, p_rst = 1'b1;
  logic [31:0] p_pc = '0, p_instr = '0;

  initial begin
    logic [63:0] item;
    forever begin
      @(negedge clk_i);
      #4;
      if (mon_en) begin
        check("pc_src_is_pc_plus_4", pc_src_o, pc_o + 32'd4);
        if (!valid_o) check("nop_when_empty", instruction_o, NOP);
        if (p_valid && p_stall && !p_sel && !p_rst) begin
          check("stall_hold_valid", {31'b0, valid_o}, 32'd1);
          check("stall_hold_pc", pc_o, p_pc);
          check("stall_hold_instr", instruction_o, p_instr);
        end
        if (!reset_i && !pc_select_i) begin
          extend_stream();
          if (valid_o && !stall_i) begin
            item = exp_q.pop_front();
            check("stream_pc", pc_o, item[63:32]);
            check("stream_instr", instruction_o, item[31:0]);
            n_out++;
          end else if (!valid_o) begin
            check("empty_pc_is_next", pc_o, exp_q[0][63:32]);
          end
        end
        if (PERF_ON) check("perf_cnt", perf_stall_cnt_o, perf_exp);
        else         check("perf_cnt_tied", perf_stall_cnt_o, 32'd0);
        if (reset_i) perf_exp = '0;
        else if (!valid_o && !stall_i && perf_exp != 32'hFFFF_FFFF) perf_exp = perf_exp + 32'd1;
        p_valid = valid_o;
        p_stall = stall_i;
        p_sel   = pc_select_i;
        p_rst   = reset_i;
        p_pc    = pc_o;
        p_instr = instruction_o;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk_i);
    #1;
  endtask

  task automatic do_redirect(input logic [31:0] t);
    pc_select_i   = 1'b1;
    pc_branch_i   = t;
    seed_stream({t[31:2], 2'b00});
    exp_addr      = {t[31:2], 2'b00};
    exp_addr_flag = 1'b1;
  endtask

  task automatic do_reset_seed();
    reset_i       = 1'b1;
    pc_select_i   = 1'b0;
    seed_stream(RESET_PC);
    exp_addr      = RESET_PC;
    exp_addr_flag = 1'b1;
  endtask

  task automatic wait_valid(input string name, input logic [31:0] exp_pc);
    for (int i = 0; i < 40; i++) begin
      tick();
      #3;
      if (valid_o) begin
        check(name, pc_o, exp_pc);
        return;
      end
    end
    check({name, "_timeout"}, {31'b0, valid_o}, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int r;
    bit found;
    reset_i     = 1'b1;
    pc_select_i = 1'b0;
    pc_branch_i = '0;
    stall_i     = 1'b0;
    do_reset_seed();
    repeat (3) tick();

    // Reset release with zero-wait memory: valid_o rises two cycles later.
    reset_i = 1'b0;
    mon_en  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick();
      #3;
      check("startup_valid", {31'b0, valid_o}, (k >= 2) ? 32'd1 : 32'd0);
      if (k == 2) check("startup_pc", pc_o, RESET_PC);
    end

    // Stall five cycles at pc 0x8; the queue fills and requests stop.
    tick();
    check("stall_start_pc", pc_o, 32'h8);
    stall_i = 1'b1;
    repeat (4) tick();
    #3;
    check("req_drops_when_full", {31'b0, imem_req_o}, 32'd0);
    check("valid_while_stalled", {31'b0, valid_o}, 32'd1);
    tick();
    stall_i = 1'b0;
    repeat (6) tick();

    // Redirect to 0x100 with two requests in flight.
    lat_min = 3;
    lat_max = 3;
    found   = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (pend_q.size() == MAX_OUT) found = 1'b1;
    end
    check("two_outstanding_reached", {31'b0, found}, 32'd1);
    do_redirect(32'h100);
    tick();
    pc_select_i = 1'b0;
    wait_valid("redirect_100_first_pc", 32'h100);
    repeat (10) tick();

    // Redirect to 0x203 in the same cycle as a response.
    lat_min = 1;
    lat_max = 1;
    repeat (10) tick();
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (imem_rvalid_i) found = 1'b1;
    end
    check("rvalid_seen_for_redirect", {31'b0, found}, 32'd1);
    do_redirect(32'h203);
    tick();
    pc_select_i = 1'b0;
    #3;
    check("redirect_203_req", {31'b0, imem_req_o}, 32'd1);
    check("redirect_203_addr", imem_addr_o, 32'h200);
    wait_valid("redirect_203_first_pc", 32'h200);

    // Grant withheld for three cycles, then four-cycle response latency.
    gnt_off = 3;
    lat_min = 4;
    lat_max = 4;
    repeat (25) tick();

    // Reset with the queue full.
    lat_min = 1;
    lat_max = 1;
    stall_i = 1'b1;
    repeat (10) tick();
    #3;
    check("full_before_reset_req", {31'b0, imem_req_o}, 32'd0);
    tick();
    stall_i = 1'b0;
    do_reset_seed();
    tick();
    #3;
    check("reset_valid", {31'b0, valid_o}, 32'd0);
    check("reset_instr", instruction_o, NOP);
    check("reset_pc", pc_o, RESET_PC);
    check("reset_req", {31'b0, imem_req_o}, 32'd0);
    check("reset_perf", perf_stall_cnt_o, 32'd0);
    tick();
    reset_i = 1'b0;
    tick();
    #3;
    check("perf_after_reset", perf_stall_cnt_o, PERF_ON ? 32'd1 : 32'd0);

    // Randomized traffic: stalls, redirects, occasional resets, slow memory.
    gnt_pct = 70;
    lat_min = 1;
    lat_max = 4;
    for (int i = 0; i < 3000; i++) begin
      tick();
      stall_i     = ($urandom_range(0, 99) < 20);
      pc_branch_i = $urandom;
      r = $urandom_range(0, 999);
      if (r < 5) begin
        do_reset_seed();
      end else if (r < 40) begin
        reset_i = 1'b0;
        do_redirect(pc_branch_i);
      end else begin
        reset_i     = 1'b0;
        pc_select_i = 1'b0;
      end
    end
    tick();
    reset_i     = 1'b0;
    pc_select_i = 1'b0;
    stall_i     = 1'b0;
    repeat (20) tick();
    check("instructions_delivered", {31'b0, n_out > 500}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
